// File: rtl/multicycle_ctrl_if.sv
// Fetch and data-memory handshake bundle for multicycle_ctrl.
// master = controller side, slave = memory side.
interface multicycle_ctrl_if #(
    parameter int FUNC_W = 3
);
    logic              inst_req_o;
    logic              inst_ack_i;
    logic [2:0]        op_i;
    logic [FUNC_W-1:0] func_i;
    logic              data_req_o;
    logic              data_ack_i;
    logic              we_data_o;

    modport master (
        output inst_req_o, data_req_o, we_data_o,
        input  inst_ack_i, op_i, func_i, data_ack_i
    );

    modport slave (
        input  inst_req_o, data_req_o, we_data_o,
        output inst_ack_i, op_i, func_i, data_ack_i
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/mem/writeback
// sequencing with a memory timeout and a single-level interrupt.
module multicycle_ctrl #(
    parameter int  FUNC_W      = 3,
    parameter int  ALUOP_W     = 4,
    parameter int  N_IRQ       = 4,
    parameter int  MEM_TIMEOUT = 16,
    localparam int IRQ_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_if.master    bus,
    input  logic                 zero_i,
    input  logic [N_IRQ-1:0]     irq_i,
    output logic                 op2_o,
    output logic [ALUOP_W-1:0]   alu_op_o,
    output logic                 reg_wr_o,
    output logic [1:0]           reg_mux_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_src_o,
    output logic                 epc_we_o,
    output logic                 int_o,
    output logic [IRQ_W-1:0]     irq_id_o,
    output logic                 we_port_o,
    output logic                 bus_err_o
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] OP_RALU  = 3'd0;
    localparam logic [2:0] OP_IALU  = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_OUT   = 3'd4;
    localparam logic [2:0] OP_BR    = 3'd5;
    localparam logic [2:0] OP_JMP   = 3'd6;
    localparam logic [2:0] OP_RETI  = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_INT
    } state_t;

    state_t             state, state_nx;
    logic [2:0]         op_q;
    logic [FUNC_W-1:0]  func_q;
    logic               int_en;
    logic [CNT_W-1:0]   cnt;
    logic               mem_to;
    logic               take_int;
    logic [ALUOP_W-1:0] alu_sel;
    logic               use_imm;
    logic [IRQ_W-1:0]   irq_low;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            func_q <= '0;
            int_en <= 1'b1;
            cnt    <= '0;
        end else begin
            if (state == S_FETCH && bus.inst_ack_i) begin
                op_q   <= bus.op_i;
                func_q <= bus.func_i;
            end
            if (state == S_EXEC && op_q == OP_RETI) int_en <= 1'b1;
            else if (state == S_INT)                int_en <= 1'b0;
            cnt <= (state == S_MEM) ? cnt + CNT_W'(1) : '0;
        end
    end

    assign mem_to   = (state == S_MEM) && !bus.data_ack_i &&
                      (cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign take_int = int_en && (|irq_i);
    assign use_imm  = (op_q == OP_IALU) || (op_q == OP_LOAD) ||
                      (op_q == OP_STORE);

    always_comb begin
        alu_sel = '0;
        case (op_q)
            OP_RALU, OP_IALU: alu_sel = ALUOP_W'(func_q);
            OP_BR:            alu_sel = ALUOP_W'(1);
            default:          alu_sel = '0;
        endcase
    end

    // Lowest index wins: scan from the top so the last hit sticks.
    always_comb begin
        irq_low = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (irq_i[i]) irq_low = IRQ_W'(i);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (bus.inst_ack_i) state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_RALU, OP_IALU:  state_nx = S_WB;
                    OP_LOAD, OP_STORE: state_nx = S_MEM;
                    OP_RETI:           state_nx = S_FETCH;
                    default:           state_nx = take_int ? S_INT : S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.data_ack_i && op_q == OP_LOAD)
                    state_nx = S_WB;
                else if (bus.data_ack_i || mem_to)
                    state_nx = take_int ? S_INT : S_FETCH;
            end
            S_WB:    state_nx = take_int ? S_INT : S_FETCH;
            S_INT:   state_nx = S_FETCH;
            default: state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        bus.inst_req_o = 1'b0;
        bus.data_req_o = 1'b0;
        bus.we_data_o  = 1'b0;
        op2_o          = 1'b0;
        alu_op_o       = '0;
        reg_wr_o       = 1'b0;
        reg_mux_o      = 2'b00;
        pc_we_o        = 1'b0;
        pc_src_o       = 2'b00;
        epc_we_o       = 1'b0;
        int_o          = 1'b0;
        irq_id_o       = '0;
        we_port_o      = 1'b0;
        bus_err_o      = 1'b0;
        // Reset gates outputs directly so a mid-MEM reset drops the bus at once.
        if (rst) begin
            if (state == S_EXEC || state == S_WB) begin
                alu_op_o = alu_sel;
                op2_o    = use_imm;
            end
            case (state)
                S_FETCH: bus.inst_req_o = 1'b1;
                S_EXEC: begin
                    case (op_q)
                        OP_OUT: begin
                            we_port_o = 1'b1;
                            pc_we_o   = 1'b1;
                        end
                        OP_BR: begin
                            pc_we_o  = 1'b1;
                            pc_src_o = zero_i ? 2'b01 : 2'b00;
                        end
                        OP_JMP: begin
                            pc_we_o  = 1'b1;
                            pc_src_o = 2'b01;
                        end
                        OP_RETI: begin
                            pc_we_o  = 1'b1;
                            pc_src_o = 2'b11;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.data_req_o = 1'b1;
                    bus.we_data_o  = (op_q == OP_STORE);
                    if (bus.data_ack_i) begin
                        pc_we_o = (op_q == OP_STORE);
                    end else if (mem_to) begin
                        bus_err_o = 1'b1;
                        pc_we_o   = 1'b1;
                    end
                end
                S_WB: begin
                    reg_wr_o  = 1'b1;
                    reg_mux_o = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
                    pc_we_o   = 1'b1;
                end
                S_INT: begin
                    int_o    = 1'b1;
                    epc_we_o = 1'b1;
                    pc_we_o  = 1'b1;
                    pc_src_o = 2'b10;
                    irq_id_o = irq_low;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl using a
// per-instruction cycle-list reference model.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       zero_i;
    logic [3:0] irq_i;
    logic       op2_o;
    logic [3:0] alu_op_o;
    logic       reg_wr_o;
    logic [1:0] reg_mux_o;
    logic       pc_we_o;
    logic [1:0] pc_src_o;
    logic       epc_we_o;
    logic       int_o;
    logic [1:0] irq_id_o;
    logic       we_port_o;
    logic       bus_err_o;

    multicycle_ctrl_if #(.FUNC_W(3)) bus ();

    multicycle_ctrl #(
        .FUNC_W(3), .ALUOP_W(4), .N_IRQ(4), .MEM_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .zero_i(zero_i),
        .irq_i(irq_i), .op2_o(op2_o), .alu_op_o(alu_op_o),
        .reg_wr_o(reg_wr_o), .reg_mux_o(reg_mux_o),
        .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
        .epc_we_o(epc_we_o), .int_o(int_o), .irq_id_o(irq_id_o),
        .we_port_o(we_port_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       inst_req;
        logic       op2;
        logic [3:0] alu;
        logic       reg_wr;
        logic [1:0] reg_mux;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       epc_we;
        logic       int_ack;
        logic [1:0] irq_id;
        logic       data_req;
        logic       we_data;
        logic       we_port;
        logic       bus_err;
    } out_t;

    typedef struct packed {
        logic       ia;
        logic [2:0] op;
        logic [2:0] fn;
        logic       da;
        logic       z;
        logic [3:0] irq;
    } in_t;

    int checks = 0;
    int errors = 0;
    bit ien = 1'b1;
    int dreq_n, wed_n, berr_n, int_n;

    function automatic out_t sample();
        out_t o;
        o.inst_req = bus.inst_req_o;
        o.op2      = op2_o;
        o.alu      = alu_op_o;
        o.reg_wr   = reg_wr_o;
        o.reg_mux  = reg_mux_o;
        o.pc_we    = pc_we_o;
        o.pc_src   = pc_src_o;
        o.epc_we   = epc_we_o;
        o.int_ack  = int_o;
        o.irq_id   = irq_id_o;
        o.data_req = bus.data_req_o;
        o.we_data  = bus.we_data_o;
        o.we_port  = we_port_o;
        o.bus_err  = bus_err_o;
        return o;
    endfunction

    // Ignored-input noise: stray acks outside their states must not matter.
    function automatic in_t noise(input logic [3:0] irq);
        in_t x;
        x.ia  = 1'($urandom);
        x.op  = 3'($urandom);
        x.fn  = 3'($urandom);
        x.da  = 1'($urandom);
        x.z   = 1'($urandom);
        x.irq = irq;
        return x;
    endfunction

    task automatic apply(input in_t x, output out_t o);
        @(negedge clk);
        bus.inst_ack_i = x.ia;
        bus.op_i       = x.op;
        bus.func_i     = x.fn;
        bus.data_ack_i = x.da;
        zero_i         = x.z;
        irq_i          = x.irq;
        #1;
        o = sample();
        if (o.data_req) dreq_n++;
        if (o.we_data)  wed_n++;
        if (o.bus_err)  berr_n++;
        if (o.int_ack)  int_n++;
    endtask

    // lat: MEM cycle carrying data_ack (1..16), 0 = never acked.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] fn,
                             input logic z, input int lat, input int wt,
                             input logic [3:0] irq, input string tag);
        in_t  iq[$];
        out_t eq[$];
        in_t  x;
        out_t e, o;
        logic [3:0] alu;
        logic op2, done;
        alu  = (op <= 3'd1) ? {1'b0, fn} : (op == 3'd5) ? 4'd1 : 4'd0;
        op2  = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
        done = 1'b0;
        for (int k = 0; k <= wt; k++) begin
            x = noise(irq);
            x.ia = (k == wt);
            if (k == wt) begin x.op = op; x.fn = fn; end
            e = '0; e.inst_req = 1'b1;
            iq.push_back(x); eq.push_back(e);
        end
        x = noise(irq); e = '0;
        iq.push_back(x); eq.push_back(e);
        x = noise(irq); x.z = z;
        e = '0; e.alu = alu; e.op2 = op2;
        case (op)
            3'd4: begin e.we_port = 1'b1; e.pc_we = 1'b1; done = 1'b1; end
            3'd5: begin e.pc_we = 1'b1; e.pc_src = z ? 2'b01 : 2'b00; done = 1'b1; end
            3'd6: begin e.pc_we = 1'b1; e.pc_src = 2'b01; done = 1'b1; end
            3'd7: begin e.pc_we = 1'b1; e.pc_src = 2'b11; end
            default: ;
        endcase
        iq.push_back(x); eq.push_back(e);
        if (op == 3'd2 || op == 3'd3) begin
            for (int k = 1; k <= 16; k++) begin
                x = noise(irq);
                x.da = (k == lat);
                e = '0; e.data_req = 1'b1; e.we_data = (op == 3'd3);
                if (k == lat && op == 3'd3) begin e.pc_we = 1'b1; done = 1'b1; end
                if (k == 16 && lat == 0) begin
                    e.bus_err = 1'b1; e.pc_we = 1'b1; done = 1'b1;
                end
                iq.push_back(x); eq.push_back(e);
                if (k == lat) break;
            end
        end
        if (op <= 3'd1 || (op == 3'd2 && lat != 0)) begin
            x = noise(irq);
            e = '0; e.alu = alu; e.op2 = op2; e.reg_wr = 1'b1;
            e.reg_mux = (op == 3'd2) ? 2'b01 : 2'b00; e.pc_we = 1'b1;
            iq.push_back(x); eq.push_back(e);
            done = 1'b1;
        end
        if (op == 3'd7) ien = 1'b1;
        else if (done && ien && irq != 4'd0) begin
            x = noise(irq);
            e = '0; e.int_ack = 1'b1; e.epc_we = 1'b1; e.pc_we = 1'b1;
            e.pc_src = 2'b10;
            for (int b = 3; b >= 0; b--) if (irq[b]) e.irq_id = 2'(b);
            iq.push_back(x); eq.push_back(e);
            ien = 1'b0;
        end
        for (int i = 0; i < eq.size(); i++) begin
            apply(iq[i], o);
            checks++;
            if (o !== eq[i]) begin
                errors++;
                $display("FAIL %s op=%0d cycle %0d: got %h expected %h",
                         tag, op, i, o, eq[i]);
            end
        end
    endtask

    task automatic test_reset();
        out_t o;
        #2;
        o = sample();
        checks++;
        if (o !== out_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", o);
        end
        @(negedge clk); rst = 1'b1; #1;
        o = sample();
        checks++;
        if (o.inst_req !== 1'b1 || o.data_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got %h expected inst_req only", o);
        end
    endtask

    task automatic test_alu();
        run_instr(3'd0, 3'd5, 1'b0, 0, 0, 4'd0, "ralu_f5");
        run_instr(3'd1, 3'd6, 1'b0, 0, 2, 4'd0, "ialu_f6");
    endtask

    task automatic test_load();
        dreq_n = 0; wed_n = 0;
        run_instr(3'd2, 3'd0, 1'b0, 3, 1, 4'd0, "load_ack3");
        checks++;
        if (dreq_n !== 3 || wed_n !== 0) begin
            errors++;
            $display("FAIL load_req_len: got %0d/%0d expected 3/0", dreq_n, wed_n);
        end
    endtask

    task automatic test_store_timeout();
        wed_n = 0; berr_n = 0;
        run_instr(3'd3, 3'd2, 1'b0, 0, 0, 4'd0, "store_timeout");
        checks++;
        if (wed_n !== 16 || berr_n !== 1) begin
            errors++;
            $display("FAIL store_timeout_len: got %0d/%0d expected 16/1", wed_n, berr_n);
        end
        run_instr(3'd3, 3'd1, 1'b0, 16, 0, 4'd0, "store_ack16");
    endtask

    task automatic test_irq();
        int_n = 0;
        run_instr(3'd0, 3'd3, 1'b0, 0, 0, 4'b1010, "irq_ralu");
        run_instr(3'd6, 3'd0, 1'b0, 0, 0, 4'b1010, "irq_held");
        run_instr(3'd7, 3'd0, 1'b0, 0, 0, 4'b1010, "irq_reti");
        run_instr(3'd4, 3'd0, 1'b0, 0, 0, 4'b1010, "irq_again");
        checks++;
        if (int_n !== 2) begin
            errors++;
            $display("FAIL irq_count: got %0d expected 2", int_n);
        end
        run_instr(3'd7, 3'd0, 1'b0, 0, 0, 4'd0, "irq_restore");
    endtask

    task automatic test_branch();
        run_instr(3'd5, 3'd7, 1'b0, 0, 0, 4'd0, "branch_z0");
        run_instr(3'd5, 3'd7, 1'b1, 0, 0, 4'd0, "branch_z1");
    endtask

    task automatic test_reset_mid_mem();
        in_t  x;
        out_t o;
        x = noise(4'd0); x.ia = 1'b1; x.op = 3'd2; x.da = 1'b0;
        apply(x, o);
        for (int k = 0; k < 4; k++) begin
            x = noise(4'd0); x.da = 1'b0;
            apply(x, o);
        end
        checks++;
        if (o.data_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_req: got %b expected 1", o.data_req);
        end
        #2 rst = 1'b0;
        #1 o = sample();
        checks++;
        if (o !== out_t'(0)) begin
            errors++;
            $display("FAIL mid_mem_reset: got %h expected 0", o);
        end
        @(negedge clk);
        bus.inst_ack_i = 1'b0;
        bus.data_ack_i = 1'b0;
        rst = 1'b1;
        ien = 1'b1;
        #1 o = sample();
        checks++;
        if (o.inst_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_release: got %b expected 1", o.inst_req);
        end
        run_instr(3'd0, 3'd2, 1'b0, 0, 0, 4'd0, "after_reset");
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [3:0] irq;
        int lat;
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom);
            irq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 16);
            run_instr(op, 3'($urandom), 1'($urandom), lat,
                      $urandom_range(0, 3), irq, "random");
        end
    endtask

    initial begin
        rst            = 1'b0;
        bus.inst_ack_i = 1'b0;
        bus.op_i       = 3'd0;
        bus.func_i     = 3'd0;
        bus.data_ack_i = 1'b0;
        zero_i         = 1'b0;
        irq_i          = 4'd0;
        test_reset();
        test_alu();
        test_load();
        test_store_timeout();
        test_irq();
        test_branch();
        test_reset_mid_mem();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter FUNC_W, default 3, function-field width; SHALL satisfy FUNC_W <= ALUOP_W.
REQ-002 Parameter ALUOP_W, default 4, ALU selector width.
REQ-003 Parameter N_IRQ, default 4, interrupt line count (1..16); IRQ_W = max(1, clog2(N_IRQ)).
REQ-004 Parameter MEM_TIMEOUT, default 16, maximum MEM-state cycles without data_ack_i (>=1).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 op_i  in  3  opcode: 000 R-ALU, 001 I-ALU, 010 LOAD, 011 STORE, 100 OUT, 101 BRANCH, 110 JUMP, 111 RETI.
REQ-008 func_i  in  FUNC_W  ALU function field.
REQ-009 inst_ack_i  in  1  instruction fetch acknowledge; op_i/func_i valid in the same cycle.
REQ-010 data_ack_i  in  1  data memory acknowledge.
REQ-011 zero_i  in  1  ALU zero flag, branch condition.
REQ-012 irq_i  in  N_IRQ  level interrupt requests.
REQ-013 inst_req_o  out  1  instruction fetch request.
REQ-014 op2_o  out  1  ALU operand-2 select: 1 = immediate.
REQ-015 alu_op_o  out  ALUOP_W  ALU selector.
REQ-016 reg_wr_o  out  1  register-file write enable.
REQ-017 reg_mux_o  out  2  write-back source: 00 ALU, 01 memory data.
REQ-018 pc_we_o  out  1  PC write enable.
REQ-019 pc_src_o  out  2  PC source: 00 PC+1, 01 target, 10 interrupt vector, 11 EPC.
REQ-020 epc_we_o  out  1  saves PC into EPC.
REQ-021 int_o  out  1  interrupt acknowledge.
REQ-022 irq_id_o  out  IRQ_W  index of the serviced interrupt.
REQ-023 data_req_o  out  1  data memory request.
REQ-024 we_data_o  out  1  data memory write enable.
REQ-025 we_port_o  out  1  output-port write enable.
REQ-026 bus_err_o  out  1  memory timeout pulse.

Function
REQ-027 States SHALL be FETCH, DECODE, EXECUTE, MEM, WRITEBACK, INT, all distinctly encoded.
REQ-028 FETCH: inst_req_o=1; inst_ack_i -> DECODE, latching op_i/func_i; otherwise stay.
REQ-029 DECODE: one cycle -> EXECUTE; all outputs 0.
REQ-030 alu_op_o: EXECUTE and WRITEBACK only; zero-extended latched func for R/I-ALU, 0 for LOAD/STORE, 1 for BRANCH, else 0; op2_o=1 for I-ALU, LOAD, STORE in those same states.
REQ-031 EXECUTE: R/I-ALU -> WRITEBACK; LOAD/STORE -> MEM.
REQ-032 EXECUTE, OUT: we_port_o=1, pc_we_o=1, pc_src_o=00. BRANCH: pc_we_o=1, pc_src_o = zero_i ? 01 : 00. JUMP: pc_we_o=1, pc_src_o=01.
REQ-033 EXECUTE, RETI: pc_we_o=1, pc_src_o=11, sets int_en -> FETCH with no interrupt check that cycle.
REQ-034 MEM: data_req_o=1, and we_data_o=1 for STORE, each held until data_ack_i. On ack: LOAD -> WRITEBACK; STORE: pc_we_o=1, pc_src_o=00, completes.
REQ-035 MEM timeout counter clears on MEM entry. After MEM_TIMEOUT cycles without ack: bus_err_o=1 for exactly one cycle, pc_we_o=1, pc_src_o=00, instruction completes with no register write.
REQ-036 WRITEBACK: reg_wr_o=1, reg_mux_o = 01 for LOAD else 00, pc_we_o=1, pc_src_o=00; instruction completes.
REQ-037 Completing instruction, except RETI: if int_en and |irq_i -> INT, else -> FETCH.
REQ-038 INT, one cycle: int_o=1, epc_we_o=1, pc_we_o=1, pc_src_o=10, irq_id_o = lowest set irq_i index, clears int_en -> FETCH.
REQ-039 Interrupts arriving mid-instruction SHALL be taken only at completion; requests during int_en=0 are held off until after RETI.
REQ-040 data_ack_i outside MEM and inst_ack_i outside FETCH SHALL be ignored.
REQ-041 Outputs not named for a state SHALL be 0 in that state; pulses last exactly one cycle.

Reset
REQ-042 rst low SHALL immediately force state FETCH, int_en=1, timeout counter 0, all outputs 0.
REQ-043 After rst deasserts, inst_req_o=1 from the first rising edge.
REQ-044 Reset in any state, including mid-MEM, SHALL drop data_req_o and we_data_o asynchronously.

Verification
REQ-045 R-ALU, func=101, ack in FETCH -> DECODE; EXECUTE alu_op_o=0101, op2_o=0; WRITEBACK reg_wr_o=1, reg_mux_o=00, pc_we_o=1; FETCH again 3 cycles after ack.
REQ-046 LOAD, data_ack_i on the 3rd MEM cycle -> data_req_o high for 3 cycles, we_data_o=0; WRITEBACK reg_mux_o=01.
REQ-047 STORE, no ack, MEM_TIMEOUT=16 -> we_data_o high 16 cycles; bus_err_o pulse on MEM cycle 16; pc_we_o=1; then FETCH.
REQ-048 irq_i=1010 during R-ALU -> after WRITEBACK: INT with irq_id_o=1, epc_we_o=1, pc_src_o=10; held requests ignored until RETI (pc_src_o=11), then the next completed instruction enters INT again.
REQ-049 BRANCH with zero_i=0 -> pc_src_o=00; with zero_i=1 -> pc_src_o=01; both pc_we_o=1, alu_op_o=0001.
REQ-050 rst low on MEM cycle 2 of a LOAD -> all outputs 0 before the next edge; after release, FETCH with inst_req_o=1.
